// File: rtl/bubbled_or_pkg.sv
// Shared constants, capture-mode encoding and width helper for the bubbled OR event latch.
// Purely declarative: no logic, no state.
package bubbled_or_pkg;

  localparam int MAX_INPUTS = 32;

  typedef enum logic {
    CAPTURE_LEVEL = 1'b0,
    CAPTURE_EDGE  = 1'b1
  } capture_mode_e;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for asynchronous request lines, 2 cycles latency, no backpressure.
// Both stages clear to 0 on synchronous reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bubbled_or_event_latch.sv
// Interrupt aggregator: per-input inversion, level/edge capture into sticky pending bits, enable, W1C, lowest-index encode.
// Latency 1 cycle input-to-Result (3 with BUBBLED_OR_SYNC_EN); no backpressure, captured events held until cleared.
module bubbled_or_event_latch
  import bubbled_or_pkg::*;
#(
  parameter int                    NUM_INPUTS   = 6,
  parameter logic [NUM_INPUTS-1:0] BUBBLES_MASK = '0,
  parameter logic [NUM_INPUTS-1:0] EDGE_MASK    = '0,
  localparam int                   IDX_W        = clog2_min1(NUM_INPUTS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] Inputs,
  input  logic [NUM_INPUTS-1:0] Enable_mask,
  input  logic [NUM_INPUTS-1:0] Clear_mask,
  output logic [NUM_INPUTS-1:0] Pending,
  output logic                  Result,
  output logic [IDX_W-1:0]      First_index
);

  generate
    if (NUM_INPUTS < 2 || NUM_INPUTS > MAX_INPUTS) begin : g_bad_width
      $error("bubbled_or_event_latch: NUM_INPUTS=%0d outside 2..%0d", NUM_INPUTS, MAX_INPUTS);
    end
  endgenerate

  logic [NUM_INPUTS-1:0] inputs_sync;
  logic [NUM_INPUTS-1:0] active;
  logic [NUM_INPUTS-1:0] prev_q;
  logic [NUM_INPUTS-1:0] evt;
  logic [NUM_INPUTS-1:0] masked;

`ifdef BUBBLED_OR_SYNC_EN
  sync_2ff #(
    .WIDTH(NUM_INPUTS)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (Inputs),
    .q    (inputs_sync)
  );
`else
  assign inputs_sync = Inputs;
`endif

  assign active = inputs_sync ^ BUBBLES_MASK;

  // prev_q tracks the live value even in reset, so a line held active across release is not an edge.
  always_ff @(posedge clock) begin
    prev_q <= active;
  end

  always_comb begin
    evt = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (capture_mode_e'(EDGE_MASK[i]) == CAPTURE_EDGE) begin
        evt[i] = active[i] & ~prev_q[i];
      end else begin
        evt[i] = active[i];
      end
    end
  end

  // Set term is ORed after the clear so a simultaneous set wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      Pending <= '0;
    end else begin
      Pending <= (Pending & ~Clear_mask) | (evt & Enable_mask);
    end
  end

  assign masked = Pending & Enable_mask;
  assign Result = |masked;

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    First_index = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (masked[i]) begin
        First_index = IDX_W'(i);
      end
    end
  end

endmodule

// File: tb/tb_bubbled_or_event_latch.sv
// Randomised and directed self-check of bubbled_or_event_latch against a bit-list reference model.
module tb_bubbled_or_event_latch;

  localparam int N = 6;
  localparam logic [N-1:0] BUB  = 6'b000001;
  localparam logic [N-1:0] EDGM = 6'b000100;

  logic         clock;
  logic         reset;
  logic [N-1:0] Inputs;
  logic [N-1:0] Enable_mask;
  logic [N-1:0] Clear_mask;
  logic [N-1:0] Pending;
  logic         Result;
  logic [2:0]   First_index;

  int checks = 0;
  int errors = 0;

  // Reference state: one flag per input plus the last observed "asserted" value of each line.
  bit model_pend [N];
  bit last_seen  [N];

  bubbled_or_event_latch #(
    .NUM_INPUTS  (N),
    .BUBBLES_MASK(BUB),
    .EDGE_MASK   (EDGM)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .Inputs     (Inputs),
    .Enable_mask(Enable_mask),
    .Clear_mask (Clear_mask),
    .Pending    (Pending),
    .Result     (Result),
    .First_index(First_index)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [N-1:0] model_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = model_pend[i];
    return v;
  endfunction

  // Event list: which lines are "asserted" (after inversion) and, for edge lines, newly so.
  function automatic void model_clock();
    bit asserted;
    bit fired;
    for (int i = 0; i < N; i++) begin
      asserted = (Inputs[i] != BUB[i]);
      fired    = EDGM[i] ? (asserted && !last_seen[i]) : asserted;
      if (reset) model_pend[i] = 1'b0;
      else if (fired && Enable_mask[i]) model_pend[i] = 1'b1;
      else if (Clear_mask[i]) model_pend[i] = 1'b0;
      last_seen[i] = asserted;
    end
  endfunction

  task automatic check_model(input string tag);
    int first;
    first = -1;
    for (int i = 0; i < N; i++)
      if (first < 0 && model_pend[i] && Enable_mask[i]) first = i;
    check({tag, ".pend"}, 32'(Pending), 32'(model_vec()));
    check({tag, ".res"}, 32'(Result), (first >= 0) ? 32'd1 : 32'd0);
    check({tag, ".idx"}, 32'(First_index), (first >= 0) ? 32'(first) : 32'd0);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_clock();
    #1;
    check_model("cyc");
  endtask

  initial begin
    reset       = 1'b1;
    Inputs      = '0;
    Enable_mask = '1;
    Clear_mask  = '0;
    for (int i = 0; i < N; i++) begin
      model_pend[i] = 1'b0;
      last_seen[i]  = 1'b0;
    end
    cycle();
    cycle();
    check("reset_pend", 32'(Pending), 32'd0);
    check("reset_res", 32'(Result), 32'd0);
    check("reset_idx", 32'(First_index), 32'd0);

    // Bubbled input 0 idle low reads as asserted.
    reset = 1'b0;
    cycle();
    check("bubble_pend", 32'(Pending), 32'h01);
    check("bubble_res", 32'(Result), 32'd1);
    check("bubble_idx", 32'(First_index), 32'd0);

    // Edge line 2: held high captures once, clear sticks while held.
    Inputs = 6'b000001; Clear_mask = 6'b000001;
    cycle();
    check("deassert0_clr", 32'(Pending), 32'h00);
    Clear_mask = '0; Inputs = 6'b000101;
    cycle();
    check("edge_set", 32'(Pending), 32'h04);
    for (int k = 0; k < 9; k++) cycle();
    check("edge_hold", 32'(Pending), 32'h04);
    Clear_mask = 6'b000100;
    cycle();
    check("edge_clr", 32'(Pending), 32'h00);
    Clear_mask = '0;
    for (int k = 0; k < 3; k++) cycle();
    check("edge_no_reset", 32'(Pending), 32'h00);

    // Level line 3 with clear in the same cycle: set wins.
    Inputs = 6'b001101; Clear_mask = 6'b001000;
    cycle();
    check("set_wins", 32'(Pending), 32'h08);
    cycle();
    check("set_wins_hold", 32'(Pending), 32'h08);
    Inputs = 6'b000101;
    cycle();
    check("level_clr", 32'(Pending), 32'h00);
    Clear_mask = '0;

    // Enable masking is combinational and leaves bits pending.
    Inputs = 6'b101101;
    cycle();
    Inputs = 6'b000101;
    cycle();
    check("mask_pend", 32'(Pending), 32'h28);
    Enable_mask = 6'b000111; #1;
    check("mask_res", 32'(Result), 32'd0);
    check("mask_idx", 32'(First_index), 32'd0);
    Enable_mask = 6'b100000; #1;
    check("mask_idx5", 32'(First_index), 32'd5);
    Enable_mask = '1; #1;
    check("unmask_res", 32'(Result), 32'd1);
    check("unmask_idx", 32'(First_index), 32'd3);
    check("unmask_pend", 32'(Pending), 32'h28);
    Clear_mask = '1;
    cycle();
    Clear_mask = '0;

    // Edge line high across reset release is not an edge.
    Inputs = 6'b000001;
    cycle();
    reset = 1'b1; Inputs = 6'b000101;
    cycle();
    cycle();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    check("rst_no_edge", 32'(Pending), 32'h00);
    Inputs = 6'b111010;
    cycle();
    Inputs = 6'b111110;
    cycle();
    check("all_pend", 32'(Pending), 32'h3F);
    reset = 1'b1;
    cycle();
    check("midrst_pend", 32'(Pending), 32'h00);
    check("midrst_res", 32'(Result), 32'd0);
    reset = 1'b0;

    // Random traffic with sparse clears and occasional reset.
    for (int k = 0; k < 400; k++) begin
      Inputs      = N'($urandom);
      Enable_mask = N'($urandom | $urandom);
      Clear_mask  = N'($urandom & $urandom & $urandom);
      reset       = ($urandom_range(0, 39) == 0);
      cycle();
      if (k % 7 == 0) begin
        Enable_mask = N'($urandom);
        #1;
        check_model("rnd_en");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
